// File: rtl/song_sequencer.sv
// Beat-timed playback controller for a song note ROM.
// Fetches one half-period per beat and gates the tone with an end-of-beat gap.
module song_sequencer #(
   parameter int ADDR_W     = 10,
   parameter int FREQ_W     = 18,
   parameter int BEAT_W     = 23,
   parameter int BEAT_TICKS = 3125000,
   parameter int GAP_TICKS  = 250000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic [ADDR_W-1:0] song_len,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [FREQ_W-1:0] rom_q,
   output logic [FREQ_W-1:0] half_period,
   output logic              note_valid,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] cur_addr
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] LATCH = 3'd2;
   localparam logic [2:0] PLAY  = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [BEAT_W-1:0] LAST_TICK =
      BEAT_W'(BEAT_TICKS - 1);
   localparam logic [BEAT_W-1:0] SOUND_TICKS =
      BEAT_W'(BEAT_TICKS - GAP_TICKS);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [FREQ_W-1:0] hp_q, hp_d;
   logic [BEAT_W-1:0] cnt_q, cnt_d;
   logic              busy_q, done_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cur_d   = cur_q;
      len_d   = len_q;
      hp_d    = hp_q;
      cnt_d   = cnt_q;
      // Stop overrides everything else outside IDLE.
      if (stop && state_q != IDLE) begin
         state_d = IDLE;
         addr_d  = '0;
         hp_d    = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start && !stop) begin
                  len_d  = song_len;
                  addr_d = '0;
                  if (song_len == '0) state_d = DONE;
                  else                state_d = FETCH;
               end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
               hp_d    = rom_q;
               cur_d   = addr_q;
               cnt_d   = '0;
               state_d = PLAY;
            end
            PLAY: begin
               if (!pause) begin
                  if (cnt_q == LAST_TICK) begin
                     if (addr_q == len_q - ADDR_W'(1)) begin
                        state_d = DONE;
                     end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = FETCH;
                     end
                  end else begin
                     cnt_d = cnt_q + BEAT_W'(1);
                  end
               end
            end
            DONE: begin
               hp_d    = '0;
               addr_d  = '0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cur_q   <= '0;
         len_q   <= '0;
         hp_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cur_q   <= cur_d;
         len_q   <= len_d;
         hp_q    <= hp_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
      end
   end

   assign rom_addr    = addr_q;
   assign cur_addr    = cur_q;
   assign half_period = hp_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign note_valid  = (state_q == PLAY) && (hp_q != '0) &&
                        (cnt_q < SOUND_TICKS) && !pause;

endmodule
